// File: rtl/pam_pkg.sv
// Shared definitions for the PAM symbol serializer.
//   state_t   : serializer state (IDLE, SHIFT)
//   DEF_WIDTH : default data word width
//   DEF_DEPTH : default number of PAM levels
//   bin2gray  : binary to reflected Gray code conversion
package pam_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pam_gray_enc.sv
// Symbol encoder sitting in front of the SEL output register.
// Build option: define PAM_GRAY_EN for Gray-coded symbols (adjacent PAM
// levels differ by one bit); otherwise symbols pass through as binary.
// Ports:
//   sym  : binary symbol taken from the top of the shift register
//   code : encoded symbol (Gray or binary)
module pam_gray_enc
  import pam_pkg::*;
#(
  parameter int SYM_BITS = 2
) (
  input  logic [SYM_BITS-1:0] sym,
  output logic [SYM_BITS-1:0] code
);

`ifdef PAM_GRAY_EN
  assign code = SYM_BITS'(bin2gray(32'(sym)));
`else
  assign code = sym;
`endif

endmodule

// File: rtl/pam_symbol_serializer.sv
// Serializes WIDTH-bit words into log2(DEPTH)-bit symbols, MSB first, one
// symbol per clock, to drive the select input of a PAM level mux.
// Holds one active word in a shift register and one prefetched word in a
// buffer so back-to-back words stream with no idle symbol between them.
// Build option: PAM_GRAY_EN selects Gray-coded SEL (see pam_gray_enc).
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   DATA_IN    : word to serialize
//   DATA_VALID : DATA_IN valid
//   DATA_READY : block can accept a word this cycle (no valid->ready path)
//   SEL        : registered symbol to the mux select
//   SEL_VALID  : SEL carries a data symbol
//   SYM_LAST   : SEL is the last symbol of the current word
module pam_symbol_serializer
  import pam_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           DATA_IN,
  input  logic                       DATA_VALID,
  output logic                       DATA_READY,
  output logic [$clog2(DEPTH)-1:0]   SEL,
  output logic                       SEL_VALID,
  output logic                       SYM_LAST
);

  localparam int SYM_BITS = $clog2(DEPTH);
  localparam int SYMS     = WIDTH / SYM_BITS;
  localparam int CNT_W    = (SYMS > 1) ? $clog2(SYMS) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     buf_word;
  logic                 buf_full;
  logic [SYM_BITS-1:0]  sym_code;
  logic [SYM_BITS-1:0]  sel_p1;
  logic                 vld_p1;
  logic                 last_p1;
  logic                 accept;
  logic                 at_last;

  assign DATA_READY = !RST && !buf_full;
  assign accept     = DATA_VALID && DATA_READY;
  assign at_last    = (cnt == CNT_W'(SYMS - 1));

  pam_gray_enc #(
    .SYM_BITS (SYM_BITS)
  ) u_enc (
    .sym  (shreg[WIDTH-1 -: SYM_BITS]),
    .code (sym_code)
  );

  // Stage p0 -> p1: symbol selection and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      buf_word <= '0;
      buf_full <= 1'b0;
      sel_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        sel_p1  <= sym_code;
        vld_p1  <= 1'b1;
        last_p1 <= at_last;
      end else begin
        sel_p1  <= '0;
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A buffered word takes priority; with the buffer full no new
          // word can be accepted, so the two branches never collide.
          if (buf_full) begin
            shreg    <= buf_word;
            buf_full <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end else if (accept) begin
            shreg <= DATA_IN;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            cnt <= '0;
            if (buf_full) begin
              // Reload without a bubble
              shreg    <= buf_word;
              buf_full <= 1'b0;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else begin
            shreg <= shreg << SYM_BITS;
            cnt   <= cnt + CNT_W'(1);
          end
          // Accept only happens with the buffer empty, so this never
          // overrides a same-edge drain of a held word.
          if (accept) begin
            buf_word <= DATA_IN;
            buf_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SEL       = sel_p1;
  assign SEL_VALID = vld_p1;
  assign SYM_LAST  = last_p1;

endmodule

// File: tb/tb_pam_symbol_serializer.sv
// Directed testbench for pam_symbol_serializer at default parameters
// (WIDTH=64, DEPTH=4). Expected symbols follow the Gray option when the
// bench is built with PAM_GRAY_EN.
module tb_pam_symbol_serializer;

  logic        CLK;
  logic        RST;
  logic [63:0] DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic [1:0]  SEL;
  logic        SEL_VALID;
  logic        SYM_LAST;

  int n_tests;
  int n_fail;
  logic [1:0] first4 [4];

  pam_symbol_serializer dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .SEL        (SEL),
    .SEL_VALID  (SEL_VALID),
    .SYM_LAST   (SYM_LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] enc(input logic [1:0] s);
`ifdef PAM_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_sel"},  64'(SEL),       64'd0);
    check({tag, "_vld"},  64'(SEL_VALID), 64'd0);
    check({tag, "_last"}, 64'(SYM_LAST),  64'd0);
  endtask

  // Consumes 32 clocks and checks one full word on SEL. DATA_VALID is
  // dropped after the first of those edges.
  task automatic run_word(input logic [63:0] w, input bit chk_busy, input string tag);
    logic [1:0] s;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 0) DATA_VALID = 1'b0;
      s = w[63-2*k -: 2];
      check({tag, "_sel"},  64'(SEL),       64'(enc(s)));
      check({tag, "_vld"},  64'(SEL_VALID), 64'd1);
      check({tag, "_last"}, 64'(SYM_LAST),  64'(k == 31));
      if (chk_busy && k < 31) check({tag, "_rdy_busy"}, 64'(DATA_READY), 64'd0);
      if (k < 4) first4[k] = SEL;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp5 [4];
    logic [63:0] words6 [3];
    n_tests = 0;
    n_fail  = 0;
    RST = 1'b1;
    DATA_IN = '0;
    DATA_VALID = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) tick();
    check_idle("rst");
    check("rst_rdy", 64'(DATA_READY), 64'd0);
    RST = 1'b0;
    #1;
    check("rel_rdy", 64'(DATA_READY), 64'd1);

    // Single word, then idle
    DATA_IN = 64'hE400_0000_0000_0000;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    check_idle("w1_lat");
    run_word(64'hE400_0000_0000_0000, 1'b0, "w1");
    check("w1_s0", 64'(first4[0]), 64'(enc(2'd3)));
    check("w1_s3", 64'(first4[3]), 64'(enc(2'd0)));
    tick();
    check_idle("w1_end");

    // Back-to-back words with DATA_VALID held for two accepts
    DATA_IN = 64'hFFFF_FFFF_FFFF_FFFF;
    DATA_VALID = 1'b1;
    tick();
    DATA_IN = 64'h0;
    run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "b2b_a");
    run_word(64'h0, 1'b0, "b2b_b");
    tick();
    check_idle("b2b_end");

    // Reset at symbol 10 with a word buffered
    DATA_IN = 64'h5555_5555_5555_5555;
    DATA_VALID = 1'b1;
    tick();
    DATA_IN = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    DATA_VALID = 1'b0;
    check("mid_rdy_full", 64'(DATA_READY), 64'd0);
    for (int i = 0; i < 9; i++) tick();
    check("mid_vld_pre", 64'(SEL_VALID), 64'd1);
    RST = 1'b1;
    tick();
    check_idle("mid_rst");
    check("mid_rst_rdy", 64'(DATA_READY), 64'd0);
    RST = 1'b0;
    #1;
    check("mid_rel_rdy", 64'(DATA_READY), 64'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("mid_flush_vld", 64'(SEL_VALID), 64'd0);
    end

    // Symbol coding check
`ifdef PAM_GRAY_EN
    exp5 = '{2'd0, 2'd1, 2'd3, 2'd2};
`else
    exp5 = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    DATA_IN = 64'h1B00_0000_0000_0000;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    run_word(64'h1B00_0000_0000_0000, 1'b0, "code");
    for (int k = 0; k < 4; k++) check("code_hand", 64'(first4[k]), 64'(exp5[k]));
    tick();
    check_idle("code_end");

    // One-cycle pulses every 40 cycles
    words6[0] = 64'h0123_4567_89AB_CDEF;
    words6[1] = 64'hFEDC_BA98_7654_3210;
    words6[2] = 64'hA5A5_5A5A_C3C3_3C3C;
    for (int i = 0; i < 8; i++) tick();
    for (int w = 0; w < 3; w++) begin
      DATA_IN = words6[w];
      DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      check_idle("pulse_acc");
      run_word(words6[w], 1'b0, "pulse");
      for (int i = 0; i < 7; i++) begin
        tick();
        check_idle("pulse_gap");
      end
    end
    tick();
    check_idle("pulse_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
